// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, byte length and
// master operation codes used by both byte engines.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK,
    S_TX,
    S_TX_ACK,
    S_WAIT_STOP
  } i2c_tgt_state_t;

  localparam int C_BYTE_LEN = 8;

  localparam logic [1:0] C_OP_IDLE  = 2'd0;
  localparam logic [1:0] C_OP_WRITE = 2'd1;
  localparam logic [1:0] C_OP_READ  = 2'd2;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizer for one asynchronous bus line plus edge detection.
// Ports: clk, rst (async high), d_i line in; level_o synced level,
// rise_o / fall_o one-cycle edge strobes.
module i2c_sync_edge #(
  parameter int C_SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [C_SYNC_STAGES-1:0] sync_q;
  logic                     prev_q;

  // Reset to 1 (idle bus level) so release of reset never looks like an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[C_SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[C_SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[C_SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target byte engine: START/STOP detection, 7-bit address match,
// write-byte reception and read-byte service on an open-drain SDA.
// Ports: clk, rst (async high), scl in, sda inout (pull-low only),
// rx_data/rx_valid write bytes, tx_data/tx_req read bytes,
// busy, rw, nack_rcvd status.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  C_ADDR        = 7'h1A,
  parameter int          C_SYNC_STAGES = 2,
  parameter logic [15:0] C_HOLD_CYCLES = 16'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       rw,
  output logic       nack_rcvd
);

  localparam logic [3:0] C_LAST = 4'(C_BYTE_LEN - 1);
  localparam logic [3:0] C_FULL = 4'(C_BYTE_LEN);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.C_SYNC_STAGES(C_SYNC_STAGES)) u_scl (
    .clk    (clk),
    .rst    (rst),
    .d_i    (scl),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge #(.C_SYNC_STAGES(C_SYNC_STAGES)) u_sda (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sda),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        busy_q, busy_d;
  logic        rw_q, rw_d;
  logic        nack_q, nack_d;
  logic        oe_q, oe_d;
  logic        pend_q, pend_d;
  logic        pend_oe_q, pend_oe_d;
  logic [15:0] hold_q, hold_d;

  logic       start_det, stop_det;
  logic       drv_req, drv_val;
  logic       tx_req_c;
  logic [7:0] rx_byte;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rx_byte   = {shift_q[6:0], sda_lvl};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      oe_q       <= 1'b0;
      pend_q     <= 1'b0;
      pend_oe_q  <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      nack_q     <= nack_d;
      oe_q       <= oe_d;
      pend_q     <= pend_d;
      pend_oe_q  <= pend_oe_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    nack_d     = 1'b0;
    oe_d       = oe_q;
    pend_d     = pend_q;
    pend_oe_d  = pend_oe_q;
    hold_d     = hold_q;
    drv_req    = 1'b0;
    drv_val    = 1'b0;
    tx_req_c   = 1'b0;

    // Deferred SDA change: applied once the hold delay has elapsed
    if (pend_q) begin
      if (hold_q <= 16'd1) begin
        oe_d   = pend_oe_q;
        pend_d = 1'b0;
      end else begin
        hold_d = hold_q - 16'd1;
      end
    end

    if (start_det || stop_det) begin
      state_d = start_det ? S_ADDR : S_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_WAIT_STOP: begin
        end
        S_ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == C_LAST) begin
              if (rx_byte[7:1] == C_ADDR) begin
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
                state_d = S_ADDR_ACK;
                if (rx_byte[0]) begin
                  tx_req_c = 1'b1;
                  shift_d  = tx_data;
                end
              end else begin
                state_d = S_WAIT_STOP;
              end
            end
          end
        end
        S_ADDR_ACK, S_RX_ACK: begin
          // 8th fall pulls SDA low; 9th rise ends the ACK slot
          if (scl_fall) begin
            drv_req = 1'b1;
            drv_val = 1'b1;
          end else if (scl_rise) begin
            cnt_d = '0;
            if (state_q == S_RX_ACK || !rw_q) begin
              state_d = S_RX;
            end else begin
              state_d = S_TX;
            end
          end
        end
        S_RX: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == C_LAST) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              state_d    = S_RX_ACK;
            end
          end else if (scl_fall) begin
            drv_req = 1'b1;
            drv_val = 1'b0;
          end
        end
        S_TX: begin
          // cnt = bits already clocked out; next bit is shift[7-cnt]
          if (scl_rise) begin
            if (cnt_q != C_FULL) begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (scl_fall) begin
            drv_req = 1'b1;
            if (cnt_q == C_FULL) begin
              drv_val = 1'b0;
              state_d = S_TX_ACK;
            end else begin
              drv_val = ~shift_q[~cnt_q[2:0]];
            end
          end
        end
        S_TX_ACK: begin
          if (scl_rise) begin
            cnt_d = '0;
            if (!sda_lvl) begin
              tx_req_c = 1'b1;
              shift_d  = tx_data;
              state_d  = S_TX;
            end else begin
              nack_d  = 1'b1;
              state_d = S_WAIT_STOP;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (drv_req) begin
      pend_d    = 1'b1;
      pend_oe_d = drv_val;
      hold_d    = C_HOLD_CYCLES;
    end
  end

  assign sda       = oe_q ? 1'b0 : 1'bz;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_c;
  assign busy      = busy_q;
  assign rw        = rw_q;
  assign nack_rcvd = nack_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, scoreboard queues for
// rx bytes and tx loads checked by an independent monitor.
module tb_i2c_target;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy, rw, nack_rcvd;
  wire        sda;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy),
    .rw       (rw),
    .nack_rcvd(nack_rcvd)
  );

  int total = 0;
  int bad   = 0;
  int nack_cnt  = 0;
  int drove_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an output
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        total++;
        if (exp_rx.size() == 0) begin
          bad++;
          $display("FAIL rx_unexpected: got %0h want none", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_rx.pop_front();
          if (rx_data !== e) begin
            bad++;
            $display("FAIL rx_data: got %0h want %0h", rx_data, e);
          end
        end
      end
      if (tx_req) begin
        total++;
        if (exp_tx.size() == 0) begin
          bad++;
          $display("FAIL tx_req_unexpected: tx_data %0h", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          if (tx_data !== e) begin
            bad++;
            $display("FAIL tx_load: got %0h want %0h", tx_data, e);
          end
        end
      end
      if (nack_rcvd) nack_cnt++;
      if (!m_oe && sda === 1'b0) drove_cnt++;
    end
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start;
    m_oe = 1'b0; scl = 1'b1; wq(Q);
    m_oe = 1'b1; wq(Q);
    scl = 1'b0;
  endtask

  task automatic m_rstart;
    wq(Q); m_oe = 1'b0; wq(Q);
    scl = 1'b1; wq(Q);
    m_oe = 1'b1; wq(Q);
    scl = 1'b0;
  endtask

  task automatic m_stop;
    wq(Q); m_oe = 1'b1; wq(Q);
    scl = 1'b1; wq(Q);
    m_oe = 1'b0; wq(2 * Q);
  endtask

  task automatic m_bit(input logic b, output logic s);
    wq(Q); m_oe = ~b; wq(Q);
    scl = 1'b1; wq(Q);
    s = sda; wq(Q);
    scl = 1'b0;
  endtask

  task automatic m_write(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    m_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic m_read(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      b[i] = s;
    end
    m_bit(~ack, s);
  endtask

  task automatic end_test(input string name, input int nacks);
    chk({name, "_rxq_empty"}, exp_rx.size(), 0);
    chk({name, "_txq_empty"}, exp_tx.size(), 0);
    chk({name, "_nacks"}, nack_cnt, nacks);
    nack_cnt = 0;
  endtask

  initial begin
    logic ack;
    logic [7:0] rb;

    wq(4);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_strobes", {rx_valid, tx_req, nack_rcvd}, 3'b000);
    chk("rst_busy_rw", {busy, rw}, 2'b00);
    chk("rst_sda", sda, 1'b1);
    rst = 1'b0;
    wq(Q);

    // 1: write 0xA5, 0x0F
    exp_rx.push_back(8'hA5);
    exp_rx.push_back(8'h0F);
    m_start();
    m_write(8'h34, ack);
    chk("t1_addr_ack", ack, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_rw", rw, 1'b0);
    m_write(8'hA5, ack);
    chk("t1_b0_ack", ack, 1'b1);
    m_write(8'h0F, ack);
    chk("t1_b1_ack", ack, 1'b1);
    m_stop();
    chk("t1_busy_stop", busy, 1'b0);
    end_test("t1", 0);

    // 2: foreign address
    drove_cnt = 0;
    m_start();
    m_write(8'h36, ack);
    chk("t2_addr_nack", ack, 1'b0);
    m_write(8'h55, ack);
    chk("t2_busy", busy, 1'b0);
    m_stop();
    chk("t2_never_drove", drove_cnt, 0);
    end_test("t2", 0);

    // 3: read 0xC3 (ACK), 0x81 (NACK)
    exp_tx.push_back(8'hC3);
    exp_tx.push_back(8'h81);
    tx_data = 8'hC3;
    m_start();
    m_write(8'h35, ack);
    chk("t3_addr_ack", ack, 1'b1);
    chk("t3_rw", rw, 1'b1);
    tx_data = 8'h81;
    m_read(1'b1, rb);
    chk("t3_byte0", rb, 8'hC3);
    m_read(1'b0, rb);
    chk("t3_byte1", rb, 8'h81);
    drove_cnt = 0;
    m_stop();
    chk("t3_released", drove_cnt, 0);
    chk("t3_busy_stop", busy, 1'b0);
    end_test("t3", 1);

    // 4: write 0x12, repeated START, read
    exp_rx.push_back(8'h12);
    m_start();
    m_write(8'h34, ack);
    m_write(8'h12, ack);
    chk("t4_b0_ack", ack, 1'b1);
    chk("t4_rw_w", rw, 1'b0);
    exp_tx.push_back(8'h6B);
    tx_data = 8'h6B;
    m_rstart();
    m_write(8'h35, ack);
    chk("t4_raddr_ack", ack, 1'b1);
    chk("t4_rw_r", rw, 1'b1);
    chk("t4_busy", busy, 1'b1);
    m_read(1'b0, rb);
    chk("t4_rbyte", rb, 8'h6B);
    m_stop();
    end_test("t4", 1);

    // 6: STOP after 4 bits of a write byte
    m_start();
    m_write(8'h34, ack);
    for (int i = 0; i < 4; i++) begin
      logic s;
      m_bit(1'b1, s);
    end
    m_stop();
    chk("t6_busy", busy, 1'b0);
    end_test("t6", 0);

    // 5: reset while target holds ACK low (read addr sets rw=1)
    exp_tx.push_back(8'hEE);
    tx_data = 8'hEE;
    m_start();
    for (int i = 7; i >= 0; i--) begin
      logic s;
      logic [7:0] a;
      a = 8'h35;
      m_bit(a[i], s);
    end
    wq(Q); m_oe = 1'b0; wq(Q);
    scl = 1'b1; wq(Q);
    chk("t5_ack_driven", sda, 1'b0);
    chk("t5_rw_pre", rw, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t5_sda_rel", sda, 1'b1);
    chk("t5_rx_data", rx_data, 8'h00);
    chk("t5_out", {rx_valid, tx_req, busy, rw, nack_rcvd}, 5'b0);
    wq(Q);
    rst = 1'b0;
    wq(Q);
    scl = 1'b0;
    exp_rx.push_back(8'h5A);
    m_start();
    m_write(8'h34, ack);
    chk("t5_post_ack", ack, 1'b1);
    m_write(8'h5A, ack);
    m_stop();
    end_test("t5", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
